// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: buffers DEPTH {pc, inst} pairs between the memory
// read port and decode, and keeps a held IR register that captures each popped
// pair so decode/execute can work on a stable instruction for many cycles.
//
// Handshakes: a transfer happens on a rising clk edge when valid and ready are
// both high in that cycle. A producer holding valid must keep its payload
// stable until the transfer. in_ready is a function of occupancy only, so a
// full queue refuses a push even when a pop happens in the same cycle.
// out_valid is a function of occupancy only, so out_ready is ignored when the
// queue is empty.
module inst_fetch_queue #(
  parameter int              XLEN       = 32,
  parameter int              ILEN       = 32,
  parameter int              DEPTH      = 4,
  parameter logic [ILEN-1:0] RESET_INST = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [ILEN-1:0]            in_inst,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [ILEN-1:0]            out_inst,
  input  logic                       ir_en,
  output logic [XLEN-1:0]            ir_pc,
  output logic [ILEN-1:0]            ir_inst,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [ILEN-1:0] inst_mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            push;
  logic            pop;

  // Flush masks both handshakes so a same-cycle push is dropped and a
  // same-cycle pop neither dequeues nor captures into the held IR.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  // Head entry is read straight from storage, forced to zero when empty.
  assign out_pc    = out_valid ? pc_mem[rd_ptr]   : '0;
  assign out_inst  = out_valid ? inst_mem[rd_ptr] : '0;

  // Entry storage: written only on an accepted push, PC and inst together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else if (push) begin
      pc_mem[wr_ptr]   <= in_pc;
      inst_mem[wr_ptr] <= in_inst;
    end
  end

  // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Held IR: captures the head on an enabled pop, otherwise holds (flush too).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_pc   <= '0;
      ir_inst <= RESET_INST;
    end else if (pop && ir_en) begin
      ir_pc   <= out_pc;
      ir_inst <= out_inst;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: scenario tasks drive the queue cycle by cycle;
// a scoreboard queue holds the expected {pc, inst} stream and a small
// occupancy / held-IR model supplies every expected value.
module tb_inst_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        ir_en;
  logic [31:0] ir_pc;
  logic [31:0] ir_inst;
  logic [2:0]  count;

  logic [63:0] exp_q[$];
  int          m_count;
  logic [31:0] m_ir_pc;
  logic [31:0] m_ir_inst;
  int          vectors;
  int          miscompares;

  inst_fetch_queue #(
    .XLEN(32), .ILEN(32), .DEPTH(DEPTH), .RESET_INST(32'h00000013)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .ir_en(ir_en), .ir_pc(ir_pc), .ir_inst(ir_inst), .count(count)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    exp_q.delete();
    m_count   = 0;
    m_ir_pc   = 32'h0;
    m_ir_inst = 32'h00000013;
  endtask

  // Driver + scoreboard: applies one cycle of inputs just after a posedge,
  // checks head/flags before the next edge, then checks state after it.
  task automatic cycle(input logic iv, input logic [31:0] pc, input logic [31:0] inst,
                       input logic ordy, input logic ie, input logic fl);
    logic        do_push;
    logic        do_pop;
    logic [63:0] front;
    in_valid = iv; in_pc = pc; in_inst = inst;
    out_ready = ordy; ir_en = ie; flush = fl;
    #1;
    do_push = iv && (m_count < DEPTH) && !fl;
    do_pop  = ordy && (m_count != 0) && !fl;
    vectors++;
    if (out_valid !== (m_count != 0)) begin
      miscompares++;
      $display("FAIL out_valid: got %b want %b", out_valid, (m_count != 0));
    end
    vectors++;
    if (in_ready !== (m_count < DEPTH)) begin
      miscompares++;
      $display("FAIL in_ready: got %b want %b", in_ready, (m_count < DEPTH));
    end
    front = 64'h0;
    if (m_count != 0) front = exp_q[0];
    vectors++;
    if ({out_pc, out_inst} !== front) begin
      miscompares++;
      $display("FAIL head_data: got pc=%h inst=%h want pc=%h inst=%h",
               out_pc, out_inst, front[63:32], front[31:0]);
    end
    if (do_pop) begin
      void'(exp_q.pop_front());
      m_count--;
      if (ie) begin
        m_ir_pc   = front[63:32];
        m_ir_inst = front[31:0];
      end
    end
    if (do_push) begin
      exp_q.push_back({pc, inst});
      m_count++;
    end
    if (fl) begin
      exp_q.delete();
      m_count = 0;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b0; ir_en = 1'b0; flush = 1'b0;
    vectors++;
    if (count !== 3'(m_count)) begin
      miscompares++;
      $display("FAIL count: got %0d want %0d", count, m_count);
    end
    vectors++;
    if (ir_pc !== m_ir_pc || ir_inst !== m_ir_inst) begin
      miscompares++;
      $display("FAIL held_ir: got pc=%h inst=%h want pc=%h inst=%h",
               ir_pc, ir_inst, m_ir_pc, m_ir_inst);
    end
  endtask

  task automatic test_reset();
    cycle(1'b1, 32'h40, 32'hB0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h44, 32'hB1, 1'b1, 1'b1, 1'b0);
    // Assert mid-cycle, check immediately (asynchronous)
    rst = 1'b1;
    model_reset();
    #1;
    vectors++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_flags: got count=%0d out_valid=%b in_ready=%b want 0 0 1",
               count, out_valid, in_ready);
    end
    vectors++;
    if (ir_pc !== 32'h0 || ir_inst !== 32'h00000013 || out_pc !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_ir: got ir_pc=%h ir_inst=%h out_pc=%h want 0 00000013 0",
               ir_pc, ir_inst, out_pc);
    end
    // Hold reset across an edge with stimulus present
    in_valid = 1'b1; in_pc = 32'h48; in_inst = 32'hB2; out_ready = 1'b1; ir_en = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (count !== 3'd0 || ir_inst !== 32'h00000013) begin
      miscompares++;
      $display("FAIL reset_hold: got count=%0d ir_inst=%h want 0 00000013", count, ir_inst);
    end
    in_valid = 1'b0; out_ready = 1'b0; ir_en = 1'b0;
    rst = 1'b0;
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'(4 * i), 32'hA0 + 32'(i), 1'b0, 1'b0, 1'b0);
    vectors++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_full: got count=%0d in_ready=%b want 4 0", count, in_ready);
    end
    cycle(1'b1, 32'h10, 32'hEE, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
      vectors++;
      if (ir_pc !== 32'(4 * i) || ir_inst !== 32'hA0 + 32'(i)) begin
        miscompares++;
        $display("FAIL drain_ir: got pc=%h inst=%h want pc=%h inst=%h",
                 ir_pc, ir_inst, 32'(4 * i), 32'hA0 + 32'(i));
      end
    end
    vectors++;
    if (count !== 3'd0) begin
      miscompares++;
      $display("FAIL drain_empty: got count=%0d want 0", count);
    end
  endtask

  task automatic test_wrap();
    cycle(1'b1, 32'h100, $urandom, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h104, $urandom, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 32'h108 + 32'(4 * i), $urandom, 1'b1, 1'b1, 1'b0);
      vectors++;
      if (count !== 3'd2) begin
        miscompares++;
        $display("FAIL wrap_count: got %0d want 2", count);
      end
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'h200 + 32'(4 * i), 32'hC0 + 32'(i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h2FC, 32'hDEAD, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (count !== 3'd3 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL full_pop: got count=%0d in_ready=%b want 3 1", count, in_ready);
    end
  endtask

  task automatic test_flush();
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'h300, 32'hA0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h304, 32'hA1, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h308 + 32'(4 * i), 32'hF0 + 32'(i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h3F0, 32'hBAD, 1'b1, 1'b1, 1'b1);
    vectors++;
    if (count !== 3'd0 || out_valid !== 1'b0 || ir_inst !== 32'hA1 || ir_pc !== 32'h304) begin
      miscompares++;
      $display("FAIL flush: got count=%0d out_valid=%b ir_pc=%h ir_inst=%h want 0 0 304 a1",
               count, out_valid, ir_pc, ir_inst);
    end
  endtask

  task automatic test_hold();
    cycle(1'b1, 32'h400, 32'hD0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h404, 32'hD1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (count !== 3'd1 || ir_inst !== 32'hA1 || out_pc !== 32'h404) begin
      miscompares++;
      $display("FAIL hold_discard: got count=%0d ir_inst=%h out_pc=%h want 1 a1 404",
               count, ir_inst, out_pc);
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      vectors++;
      if (ir_pc !== 32'h304 || ir_inst !== 32'hA1) begin
        miscompares++;
        $display("FAIL hold_idle: got pc=%h inst=%h want 304 a1", ir_pc, ir_inst);
      end
    end
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++)
      cycle(1'($urandom_range(0, 1)), $urandom, $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 19) == 0));
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0;
    out_ready = 1'b0; ir_en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full_pop();
    test_flush();
    test_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
